// File: rtl/counter_pkg.sv
// Shared counter types and next-state arithmetic for mod-N counters, prescalers and timers.
// Arithmetic runs at a fixed maximum width; callers zero-extend and truncate to their own width.
package counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

    localparam int CNT_MAX_W = 32;

    typedef logic [CNT_MAX_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t q;
        logic wrap;
    } next_t;

    // Up terminates at or above the limit so an out-of-range value falls back to zero.
    function automatic logic is_term(input cnt_t q, input cnt_t limit, input dir_e dir);
        logic t;
        case (dir)
            DIR_UP:   t = (q >= limit);
            DIR_DOWN: t = (q == {CNT_MAX_W{1'b0}});
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic next_t next_count(input cnt_t q, input cnt_t limit, input dir_e dir);
        next_t n;
        n.wrap = is_term(q, limit, dir);
        case (dir)
            DIR_UP:   n.q = n.wrap ? {CNT_MAX_W{1'b0}} : q + cnt_t'(1);
            DIR_DOWN: n.q = n.wrap ? limit : q - cnt_t'(1);
            default:  n.q = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod_counter_n_if.sv
// Control/status bundle of one modulo-N counter stage; the master drives controls, the counter answers.
interface mod_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             LOAD_n;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] LIMIT;
    logic             UP;
    logic             ENP;
    logic             ENT;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             WRAP;

    modport master (
        output LOAD_n, D, LIMIT, UP, ENP, ENT,
        input  Q, RCO, WRAP
    );

    modport slave (
        input  LOAD_n, D, LIMIT, UP, ENP, ENT,
        output Q, RCO, WRAP
    );
endinterface

// File: rtl/mod_counter_n.sv
// Presettable up/down modulo-(LIMIT+1) counter with '161-style ENP/ENT cascade enables.
// RCO is combinational so a chain of stages advances on a single edge.
module mod_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            CLK,
    input  logic            CLR_n,
    mod_counter_n_if.slave  bus
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    cnt_t             w_q_ext;
    cnt_t             w_lim_ext;
    dir_e             w_dir;
    logic             w_term;
    next_t            w_next;
    logic             w_count_en;
    logic [WIDTH-1:0] w_next_q;

    // Next-count arithmetic and terminal detection from the current state and controls.
    always_comb begin
        w_q_ext    = cnt_t'(r_q);
        w_lim_ext  = cnt_t'(bus.LIMIT);
        w_dir      = dir_e'(bus.UP);
        w_term     = is_term(w_q_ext, w_lim_ext, w_dir);
        w_next     = next_count(w_q_ext, w_lim_ext, w_dir);
        w_next_q   = WIDTH'(w_next.q);
        w_count_en = bus.ENP & bus.ENT;
    end

    // Count register: clear beats load beats count; WRAP is high only after a wrapping count.
    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            r_q    <= {WIDTH{1'b0}};
            r_wrap <= 1'b0;
        end else if (!bus.LOAD_n) begin
            r_q    <= bus.D;
            r_wrap <= 1'b0;
        end else if (w_count_en) begin
            r_q    <= w_next_q;
            r_wrap <= w_next.wrap;
        end else begin
            r_q    <= r_q;
            r_wrap <= 1'b0;
        end
    end

    assign bus.Q    = r_q;
    assign bus.WRAP = r_wrap;
    assign bus.RCO  = bus.ENT & w_term;

endmodule

// File: tb/tb_mod_counter_n.sv
// Directed self-checking bench for mod_counter_n: 4-bit and 8-bit stages plus a two-digit BCD cascade.
module tb_mod_counter_n;

    logic CLK = 1'b0;
    logic clr4, clr8, clru, clrt;
    int   checks = 0;
    int   errors = 0;

    mod_counter_n_if #(.WIDTH(4)) if4 ();
    mod_counter_n_if #(.WIDTH(8)) if8 ();
    mod_counter_n_if #(.WIDTH(4)) ifu ();
    mod_counter_n_if #(.WIDTH(4)) ift ();

    mod_counter_n #(.WIDTH(4)) u4      (.CLK(CLK), .CLR_n(clr4), .bus(if4));
    mod_counter_n #(.WIDTH(8)) u8      (.CLK(CLK), .CLR_n(clr8), .bus(if8));
    mod_counter_n #(.WIDTH(4)) u_units (.CLK(CLK), .CLR_n(clru), .bus(ifu));
    mod_counter_n #(.WIDTH(4)) u_tens  (.CLK(CLK), .CLR_n(clrt), .bus(ift));

    assign ift.ENT = ifu.RCO;

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        if4.LOAD_n = 1'b0; if4.D = 4'd9; if4.LIMIT = 4'd9; if4.UP = 1'b1;
        if4.ENP = 1'b1; if4.ENT = 1'b1; clr4 = 1'b1;
        tick();
        checks++; if (if4.Q !== 4'd9) begin errors++; $display("FAIL preload Q=%0d exp=9", if4.Q); end
        clr4 = 1'b0; if4.LOAD_n = 1'b0; if4.D = 4'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (if4.Q !== 4'd0) begin errors++; $display("FAIL reset_q cyc%0d Q=%0d exp=0", i, if4.Q); end
            checks++; if (if4.WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap cyc%0d WRAP=%b exp=0", i, if4.WRAP); end
        end
        if4.LOAD_n = 1'b1;
        #1;
        checks++; if (if4.RCO !== 1'b0) begin errors++; $display("FAIL reset_rco_up RCO=%b exp=0", if4.RCO); end
        if4.UP = 1'b0;
        #1;
        checks++; if (if4.RCO !== 1'b1) begin errors++; $display("FAIL reset_rco_down RCO=%b exp=1", if4.RCO); end
        if4.ENP = 1'b0;
        clr4 = 1'b1;
    endtask

    task automatic test_up_mod10();
        logic [3:0] exp_q;
        if4.LIMIT = 4'd9; if4.UP = 1'b1; if4.ENP = 1'b1; if4.ENT = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_q = 4'(i % 10);
            checks++; if (if4.Q !== exp_q) begin errors++; $display("FAIL up10_q step%0d Q=%0d exp=%0d", i, if4.Q, exp_q); end
            checks++; if (if4.RCO !== (exp_q == 4'd9)) begin errors++; $display("FAIL up10_rco step%0d RCO=%b", i, if4.RCO); end
            checks++; if (if4.WRAP !== (i == 10)) begin errors++; $display("FAIL up10_wrap step%0d WRAP=%b", i, if4.WRAP); end
        end
    endtask

    task automatic test_down_split();
        if4.LIMIT = 4'd9; if4.UP = 1'b0; if4.LOAD_n = 1'b0; if4.D = 4'd2;
        tick();
        if4.LOAD_n = 1'b1;
        checks++; if (if4.Q !== 4'd2) begin errors++; $display("FAIL down_load Q=%0d exp=2", if4.Q); end
        tick();
        checks++; if (if4.Q !== 4'd1) begin errors++; $display("FAIL down_q1 Q=%0d exp=1", if4.Q); end
        tick();
        checks++; if (if4.Q !== 4'd0) begin errors++; $display("FAIL down_q0 Q=%0d exp=0", if4.Q); end
        checks++; if (if4.RCO !== 1'b1) begin errors++; $display("FAIL down_rco0 RCO=%b exp=1", if4.RCO); end
        if4.ENP = 1'b0;
        tick();
        checks++; if (if4.Q !== 4'd0) begin errors++; $display("FAIL enp_hold Q=%0d exp=0", if4.Q); end
        checks++; if (if4.RCO !== 1'b1) begin errors++; $display("FAIL enp_rco RCO=%b exp=1", if4.RCO); end
        checks++; if (if4.WRAP !== 1'b0) begin errors++; $display("FAIL enp_wrap WRAP=%b exp=0", if4.WRAP); end
        if4.ENT = 1'b0;
        #1;
        checks++; if (if4.RCO !== 1'b0) begin errors++; $display("FAIL ent_gate RCO=%b exp=0", if4.RCO); end
        if4.ENP = 1'b1; if4.ENT = 1'b1;
        tick();
        checks++; if (if4.Q !== 4'd9) begin errors++; $display("FAIL down_wrap_q Q=%0d exp=9", if4.Q); end
        checks++; if (if4.WRAP !== 1'b1) begin errors++; $display("FAIL down_wrap WRAP=%b exp=1", if4.WRAP); end
        checks++; if (if4.RCO !== 1'b0) begin errors++; $display("FAIL down_rco9 RCO=%b exp=0", if4.RCO); end
    endtask

    task automatic test_out_of_range();
        if4.LIMIT = 4'd5; if4.UP = 1'b1; if4.LOAD_n = 1'b0; if4.D = 4'd12;
        tick();
        if4.LOAD_n = 1'b1;
        checks++; if (if4.Q !== 4'd12) begin errors++; $display("FAIL oor_load Q=%0d exp=12", if4.Q); end
        checks++; if (if4.RCO !== 1'b1) begin errors++; $display("FAIL oor_rco RCO=%b exp=1", if4.RCO); end
        tick();
        checks++; if (if4.Q !== 4'd0) begin errors++; $display("FAIL oor_up_q Q=%0d exp=0", if4.Q); end
        checks++; if (if4.WRAP !== 1'b1) begin errors++; $display("FAIL oor_up_wrap WRAP=%b exp=1", if4.WRAP); end
        if4.UP = 1'b0; if4.LOAD_n = 1'b0;
        tick();
        if4.LOAD_n = 1'b1;
        checks++; if (if4.Q !== 4'd12) begin errors++; $display("FAIL oor_dn_load Q=%0d exp=12", if4.Q); end
        checks++; if (if4.WRAP !== 1'b0) begin errors++; $display("FAIL oor_load_wrap WRAP=%b exp=0", if4.WRAP); end
        tick();
        checks++; if (if4.Q !== 4'd11) begin errors++; $display("FAIL oor_dn_q Q=%0d exp=11", if4.Q); end
        checks++; if (if4.WRAP !== 1'b0) begin errors++; $display("FAIL oor_dn_wrap WRAP=%b exp=0", if4.WRAP); end
    endtask

    task automatic test_cascade();
        int u = 0;
        int t = 0;
        ifu.LIMIT = 4'd9; ift.LIMIT = 4'd9; ifu.UP = 1'b1; ift.UP = 1'b1;
        ifu.LOAD_n = 1'b1; ift.LOAD_n = 1'b1; ifu.D = 4'd0; ift.D = 4'd0;
        ifu.ENP = 1'b1; ifu.ENT = 1'b1; ift.ENP = 1'b1;
        clru = 1'b0; clrt = 1'b0;
        tick();
        clru = 1'b1; clrt = 1'b1;
        for (int i = 1; i <= 125; i++) begin
            tick();
            if (u == 9) begin u = 0; t = (t == 9) ? 0 : t + 1; end
            else u = u + 1;
            checks++; if (ifu.Q !== 4'(u) || ift.Q !== 4'(t)) begin
                errors++; $display("FAIL bcd step%0d got=%0d%0d exp=%0d%0d", i, ift.Q, ifu.Q, t, u);
            end
            if (i == 100) begin
                checks++; if (ifu.Q !== 4'd0 || ift.Q !== 4'd0) begin
                    errors++; $display("FAIL bcd_100 got=%0d%0d exp=00", ift.Q, ifu.Q);
                end
            end
        end
        clru = 1'b0;
        tick();
        clru = 1'b1;
        checks++; if (ifu.Q !== 4'd0 || ift.Q !== 4'd2) begin
            errors++; $display("FAIL bcd_clr_units got=%0d%0d exp=20", ift.Q, ifu.Q);
        end
    endtask

    task automatic test_edges_w8();
        clr8 = 1'b0;
        if8.LOAD_n = 1'b1; if8.ENP = 1'b0; if8.ENT = 1'b1; if8.UP = 1'b1; if8.LIMIT = 8'd255;
        tick();
        clr8 = 1'b1; if8.LOAD_n = 1'b0; if8.D = 8'd254;
        tick();
        if8.LOAD_n = 1'b1; if8.ENP = 1'b1;
        checks++; if (if8.Q !== 8'd254) begin errors++; $display("FAIL w8_load Q=%0d exp=254", if8.Q); end
        tick();
        checks++; if (if8.Q !== 8'd255 || if8.WRAP !== 1'b0) begin errors++; $display("FAIL w8_255 Q=%0d WRAP=%b", if8.Q, if8.WRAP); end
        checks++; if (if8.RCO !== 1'b1) begin errors++; $display("FAIL w8_rco RCO=%b exp=1", if8.RCO); end
        tick();
        checks++; if (if8.Q !== 8'd0 || if8.WRAP !== 1'b1) begin errors++; $display("FAIL w8_wrap Q=%0d WRAP=%b exp=0/1", if8.Q, if8.WRAP); end
        if8.UP = 1'b0;
        tick();
        checks++; if (if8.Q !== 8'd255 || if8.WRAP !== 1'b1) begin errors++; $display("FAIL w8_dn_wrap Q=%0d WRAP=%b exp=255/1", if8.Q, if8.WRAP); end
        if8.LIMIT = 8'd0; if8.UP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if8.Q !== 8'd0 || if8.WRAP !== 1'b1 || if8.RCO !== 1'b1) begin
                errors++; $display("FAIL lim0_up cyc%0d Q=%0d WRAP=%b RCO=%b exp=0/1/1", i, if8.Q, if8.WRAP, if8.RCO);
            end
        end
        if8.UP = 1'b0;
        tick();
        checks++; if (if8.Q !== 8'd0 || if8.WRAP !== 1'b1) begin errors++; $display("FAIL lim0_dn Q=%0d WRAP=%b exp=0/1", if8.Q, if8.WRAP); end
    endtask

    initial begin
        clr4 = 1'b1; clr8 = 1'b1; clru = 1'b1; clrt = 1'b1;
        if4.LOAD_n = 1'b1; if4.D = 4'd0; if4.LIMIT = 4'd9; if4.UP = 1'b1; if4.ENP = 1'b0; if4.ENT = 1'b0;
        if8.LOAD_n = 1'b1; if8.D = 8'd0; if8.LIMIT = 8'd255; if8.UP = 1'b1; if8.ENP = 1'b0; if8.ENT = 1'b0;
        ifu.LOAD_n = 1'b1; ifu.D = 4'd0; ifu.LIMIT = 4'd9; ifu.UP = 1'b1; ifu.ENP = 1'b0; ifu.ENT = 1'b0;
        ift.LOAD_n = 1'b1; ift.D = 4'd0; ift.LIMIT = 4'd9; ift.UP = 1'b1; ift.ENP = 1'b0;
        test_reset();
        test_up_mod10();
        test_down_split();
        test_out_of_range();
        test_cascade();
        test_edges_w8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
